// File: rtl/multibyte_uart_rx_framed.sv
// Framed UART receiver into a character buffer; chars stored 1 cycle after the stop sample; optional parity via UART_RX_PARITY_EN.
// No backpressure: characters arriving with a full buffer or a closed frame are dropped and flagged in rx_overflow.
module multibyte_uart_rx_framed #(
  parameter int SYSTEMCLOCK        = 100_000_000,
  parameter int BAUDRATE           = 115_200,
  parameter int ELEMENT_WIDTH      = 8,
  parameter int NUMBER_OF_ELEMENTS = 256,
  parameter int IDLE_TIMEOUT_BITS  = 16,
  parameter int PARITY_ODD         = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              rx_line,
  input  logic                                              rx_empty_buffer,
  output logic [NUMBER_OF_ELEMENTS-1:0][ELEMENT_WIDTH-1:0]  rx_data,
  output logic [$clog2(NUMBER_OF_ELEMENTS):0]               rx_data_length,
  output logic                                              rx_updated_buffer,
  output logic                                              rx_frame_done,
  output logic                                              rx_overflow,
  output logic                                              rx_framing_error,
  output logic                                              rx_parity_error
);

  localparam int CLKS_PER_BIT = SYSTEMCLOCK / BAUDRATE;
  localparam int LW  = $clog2(NUMBER_OF_ELEMENTS);
  localparam int AW  = (LW > 0) ? LW : 1;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(ELEMENT_WIDTH);
  localparam int IW  = $clog2(IDLE_TIMEOUT_BITS * CLKS_PER_BIT);

  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]  IDX_LAST  = BW'(ELEMENT_WIDTH - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [LW:0]    FULL      = (LW+1)'(NUMBER_OF_ELEMENTS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                   state;
  logic                     rx_sync1, rx_sync2, rx_prev;
  logic [CW-1:0]            cnt;
  logic [BW-1:0]            bit_idx;
  logic [IW-1:0]            idle_cnt;
  logic [ELEMENT_WIDTH-1:0] shreg;
  logic                     par_bad;

`ifndef UART_RX_PARITY_EN
  logic unused_parity_sense;
  assign unused_parity_sense = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      rx_sync1          <= 1'b1;
      rx_sync2          <= 1'b1;
      rx_prev           <= 1'b1;
      cnt               <= '0;
      bit_idx           <= '0;
      idle_cnt          <= '0;
      shreg             <= '0;
      par_bad           <= 1'b0;
      rx_data           <= '0;
      rx_data_length    <= '0;
      rx_updated_buffer <= 1'b0;
      rx_frame_done     <= 1'b0;
      rx_overflow       <= 1'b0;
      rx_framing_error  <= 1'b0;
      rx_parity_error   <= 1'b0;
    end else begin
      rx_sync1          <= rx_line;
      rx_sync2          <= rx_sync1;
      rx_prev           <= rx_sync2;
      rx_updated_buffer <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync2) begin
            state    <= START;
            cnt      <= '0;
            idle_cnt <= '0;
          end else if (rx_data_length != '0 && !rx_frame_done) begin
            if (idle_cnt == IDLE_LAST) rx_frame_done <= 1'b1;
            else                       idle_cnt      <= idle_cnt + 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            // A start bit that is high again at mid-bit is a glitch
            state   <= rx_sync2 ? IDLE : DATA;
            cnt     <= '0;
            bit_idx <= '0;
            par_bad <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync2, shreg[ELEMENT_WIDTH-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= STOP;
            if (((^shreg) ^ rx_sync2) != (PARITY_ODD != 0)) begin
              par_bad         <= 1'b1;
              rx_parity_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_sync2) begin
              rx_framing_error <= 1'b1;
            end else if (!par_bad) begin
              if (rx_frame_done || rx_data_length == FULL) begin
                rx_overflow <= 1'b1;
              end else begin
                rx_data[rx_data_length[AW-1:0]] <= shreg;
                rx_data_length    <= rx_data_length + (LW+1)'(1);
                rx_updated_buffer <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Clearing overrides any store on the same cycle; the bit FSM keeps running
      if (rx_empty_buffer) begin
        rx_data           <= '0;
        rx_data_length    <= '0;
        rx_updated_buffer <= 1'b0;
        rx_frame_done     <= 1'b0;
        rx_overflow       <= 1'b0;
        rx_framing_error  <= 1'b0;
        rx_parity_error   <= 1'b0;
        idle_cnt          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_multibyte_uart_rx_framed.sv
// Scoreboard bench for multibyte_uart_rx_framed: serial stimulus, queue of expected stores, flag model.
module tb_multibyte_uart_rx_framed;
  localparam int CPB  = 10;
  localparam int N    = 4;
  localparam int EW   = 8;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;
  logic rx_empty_buffer = 1'b0;
  logic [N-1:0][EW-1:0] rx_data;
  logic [$clog2(N):0]   rx_data_length;
  logic rx_updated_buffer, rx_frame_done, rx_overflow, rx_framing_error, rx_parity_error;

  multibyte_uart_rx_framed #(
    .SYSTEMCLOCK(100), .BAUDRATE(10), .ELEMENT_WIDTH(EW),
    .NUMBER_OF_ELEMENTS(N), .IDLE_TIMEOUT_BITS(16), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line), .rx_empty_buffer(rx_empty_buffer),
    .rx_data(rx_data), .rx_data_length(rx_data_length),
    .rx_updated_buffer(rx_updated_buffer), .rx_frame_done(rx_frame_done),
    .rx_overflow(rx_overflow), .rx_framing_error(rx_framing_error),
    .rx_parity_error(rx_parity_error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [EW-1:0] d; int idx; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  longint cyc = 0;
  longint last_pulse_cyc = 0;

  // Reference model: what the buffer and flags should hold
  int            m_len;
  logic [EW-1:0] m_buf [N];
  bit            m_done, m_ovf, m_ferr, m_perr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every store pulse must match the oldest expected character
  always @(negedge clk) begin
    if (!rst && rx_updated_buffer) begin
      exp_t e;
      pulse_cnt++;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_store", rx_updated_buffer, 0);
      end else begin
        e = exp_q.pop_front();
        check("store_data", rx_data[e.idx], e.d);
        check("store_len", rx_data_length, e.idx + 1);
      end
    end
  end

  task automatic model_clear();
    m_len = 0; m_done = 0; m_ovf = 0; m_ferr = 0; m_perr = 0;
    foreach (m_buf[i]) m_buf[i] = '0;
  endtask

  task automatic hold(input logic v, input int cycles);
    rx_line = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_len"}, rx_data_length, m_len);
    check({tag, "_done"}, rx_frame_done, m_done);
    check({tag, "_ovf"}, rx_overflow, m_ovf);
    check({tag, "_ferr"}, rx_framing_error, m_ferr);
    check({tag, "_perr"}, rx_parity_error, m_perr);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_data%0d", tag, i), rx_data[i], (i < m_len) ? m_buf[i] : '0);
  endtask

  task automatic send_char(input logic [EW-1:0] d, input bit stop_ok, input bit par_ok, input int gap);
    logic p;
    if (PAR_EN && !par_ok) m_perr = 1;
    if (!stop_ok) m_ferr = 1;
    else if (PAR_EN && !par_ok) begin end
    else if (m_len == N || m_done) m_ovf = 1;
    else begin
      exp_q.push_back('{d: d, idx: m_len});
      m_buf[m_len] = d;
      m_len++;
    end
    hold(1'b0, CPB);
    for (int i = 0; i < EW; i++) hold(d[i], CPB);
    p = (^d) ^ PODD[0] ^ !par_ok;
    if (PAR_EN) hold(p, CPB);
    hold(stop_ok, CPB);
    hold(1'b1, gap * CPB);
    if (gap >= 17 && m_len >= 1) m_done = 1;
  endtask

  task automatic do_empty();
    rx_empty_buffer = 1'b1;
    @(posedge clk); #1;
    rx_empty_buffer = 1'b0;
    model_clear();
    check_state("empty");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    longint done_cyc;
    int     waited;
    model_clear();
    repeat (3) @(posedge clk); #1;
    check_state("reset");
    check("reset_pulse", rx_updated_buffer, 0);
    rst = 1'b0;
    hold(1'b1, 5 * CPB);

    // Two characters into an empty buffer
    send_char(8'h55, 1, 1, 2);
    send_char(8'hA3, 1, 1, 2);
    check_state("two_bytes");
    check("two_pulses", pulse_cnt, 2);

    // Idle timeout closes the frame 160 cycles after the stop sample
    do_empty();
    send_char(8'h3C, 1, 1, 1);
    waited = 0;
    while (!rx_frame_done && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    done_cyc = cyc;
    check("frame_done_seen", rx_frame_done, 1);
    check("frame_done_delay", done_cyc - last_pulse_cyc, 160);
    m_done = 1;
    send_char(8'h11, 1, 1, 2);
    check_state("after_frame");

    // Framing error and start glitch
    do_empty();
    send_char(8'h7E, 0, 1, 2);
    check_state("framing");
    hold(1'b0, 3);
    hold(1'b1, 3 * CPB);
    check_state("glitch");

    // Overflow on a full buffer
    do_empty();
    for (int i = 0; i < 5; i++) send_char(8'(8'h20 + i), 1, 1, 1);
    check_state("full");
    do_empty();

    if (PAR_EN) begin
      send_char(8'h01, 1, 0, 2);
      check_state("par_bad");
      send_char(8'h01, 1, 1, 2);
      check_state("par_good");
      do_empty();
    end

    // Reset in the middle of a character
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    model_clear();
    check_state("mid_reset");
    rst = 1'b0;
    hold(1'b1, 3 * CPB);
    send_char(8'h9A, 1, 1, 2);
    check_state("after_reset");

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      logic [EW-1:0] d;
      bit sok, pok;
      int gap;
      d   = EW'($urandom);
      sok = ($urandom_range(0, 9) != 0);
      pok = ($urandom_range(0, 7) != 0);
      gap = ($urandom_range(0, 4) == 0) ? 20 : $urandom_range(1, 3);
      send_char(d, sok, pok, gap);
      check_state("rand");
      if ($urandom_range(0, 3) == 0) do_empty();
    end

    hold(1'b1, 2 * CPB);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
